// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_monitor
//  Description : Samples a free-running 4-bit counter every clock, counts
//                15->0 wrap-arounds and queues event records (WRAP / THRESH,
//                optionally SKIP) in a small FIFO behind a valid/ready port.
//                Optional feature macro: COUNT_MONITOR_SKIP_CHECK_EN enables
//                sequence-violation detection (SKIP records, skip_err pulse,
//                resynchronisation after a violation).
//  Ports       : clk          - clock, all logic on rising edge
//                rst          - asynchronous active-high reset
//                count_in     - sampled counter value
//                event_valid  - head FIFO record valid
//                event_ready  - consumer accepts head record
//                event_type   - 01 WRAP, 10 SKIP, 11 THRESH
//                event_data   - record payload
//                wrap_total   - wraps since reset (mod 256)
//                skip_err     - one-cycle pulse on a detected skip
//                overflow     - sticky: a record was dropped on a full FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module count_monitor #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] WRAP_THRESH = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [1:0] event_type,
    output logic [7:0] event_data,
    output logic [7:0] wrap_total,
    output logic       skip_err,
    output logic       overflow
);

    localparam int             c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_EV_WRAP   = 2'b01;
    localparam logic [1:0] c_EV_SKIP   = 2'b10;
    localparam logic [1:0] c_EV_THRESH = 2'b11;

    typedef enum logic [0:0] {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic [7:0]          wrap_total_q, wrap_total_d;
    logic                skip_err_q, skip_err_d;
    logic                overflow_q, overflow_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]          fifo_mem_q [FIFO_DEPTH];

    logic [7:0]          w_wrap_next;
    logic                w_push_req;
    logic [9:0]          w_push_rec;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [9:0]          w_head;

    assign w_wrap_next = wrap_total_q + 8'd1;

`ifdef COUNT_MONITOR_SKIP_CHECK_EN
    logic [3:0] w_expected;
    assign w_expected = prev_q + 4'd1;
`endif

    // ------------------------------------------------------------------
    // Sequence tracking FSM: next state and record generation
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        prev_d       = count_in;        // prev follows the sample in both states
        wrap_total_d = wrap_total_q;
        skip_err_d   = 1'b0;
        w_push_req   = 1'b0;
        w_push_rec   = 10'd0;

        case (state_q)
            ST_SYNC: begin
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (prev_q == 4'hF && count_in == 4'h0) begin
                    wrap_total_d = w_wrap_next;
                    w_push_req   = 1'b1;
                    // THRESH replaces the WRAP record for the crossing wrap
                    w_push_rec   = {(w_wrap_next == WRAP_THRESH) ? c_EV_THRESH : c_EV_WRAP,
                                    w_wrap_next};
                end
`ifdef COUNT_MONITOR_SKIP_CHECK_EN
                else if (count_in != w_expected) begin
                    w_push_req = 1'b1;
                    w_push_rec = {c_EV_SKIP, w_expected, count_in};
                    skip_err_d = 1'b1;
                    state_d    = ST_SYNC;
                end
`endif
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO control
    // ------------------------------------------------------------------
    assign w_empty = (cnt_q == '0);
    assign w_full  = (cnt_q == c_FULL_CNT);
    assign w_pop   = !w_empty && event_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_comb begin
        rd_ptr_d   = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        overflow_d = overflow_q | (w_push_req & ~w_push);
        cnt_d      = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            prev_q       <= 4'd0;
            wrap_total_q <= 8'd0;
            skip_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_total_q <= wrap_total_d;
            skip_err_q   <= skip_err_d;
            overflow_q   <= overflow_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Storage needs no reset: the occupancy count alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= w_push_rec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head record is forced to zero while the FIFO is empty so
    // the reset values appear immediately on an asynchronous reset.
    // ------------------------------------------------------------------
    assign w_head      = fifo_mem_q[rd_ptr_q];
    assign event_valid = !w_empty;
    assign event_type  = event_valid ? w_head[9:8] : 2'b00;
    assign event_data  = event_valid ? w_head[7:0] : 8'h00;
    assign wrap_total  = wrap_total_q;
    assign skip_err    = skip_err_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_monitor
//  Description : Scoreboard bench for count_monitor (FIFO_DEPTH=4,
//                WRAP_THRESH=2). Stimulus pushes expected records into a
//                queue; a monitor pops and compares on every handshake.
//                Honours COUNT_MONITOR_SKIP_CHECK_EN for skip expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_monitor;

    localparam logic [1:0] c_WRAP   = 2'b01;
    localparam logic [1:0] c_SKIP   = 2'b10;
    localparam logic [1:0] c_THRESH = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_type;
    logic [7:0] event_data;
    logic [7:0] wrap_total;
    logic       skip_err;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [9:0] exp_q [$];
    logic [9:0] mon_exp;

    always #5 clk = ~clk;

    count_monitor #(
        .FIFO_DEPTH  (4),
        .WRAP_THRESH (8'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_type  (event_type),
        .event_data  (event_data),
        .wrap_total  (wrap_total),
        .skip_err    (skip_err),
        .overflow    (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one sample at a falling edge; return at the next falling edge
    task automatic tick(input logic [3:0] v);
        count_in = v;
        @(negedge clk);
    endtask

    task automatic count_seq(input int from, input int to);
        for (int v = from; v <= to; v++) begin
            logic [31:0] vv;
            vv = v;
            tick(vv[3:0]);
        end
    endtask

    // Count 1..15 then 0; optionally expect the resulting record
    task automatic wrap_cycle(input logic push, input logic [1:0] t, input logic [7:0] d);
        count_seq(1, 15);
        if (push) exp_q.push_back({t, d});
        tick(4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: just after each falling edge the handshake inputs are settled
    always @(negedge clk) begin
        #1;
        if (!rst && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_record: got %0h expected none", {event_type, event_data});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("record", {22'd0, event_type, event_data}, {22'd0, mon_exp});
            end
        end
    end

    initial begin
        rst         = 1'b1;
        count_in    = 4'd0;
        event_ready = 1'b1;
        #1;
        chk("rst_valid",    event_valid, 0);
        chk("rst_type",     event_type,  0);
        chk("rst_data",     event_data,  0);
        chk("rst_total",    wrap_total,  0);
        chk("rst_skip_err", skip_err,    0);
        chk("rst_overflow", overflow,    0);
        @(negedge clk);
        rst = 1'b0;

        // First wrap with a reference count starting at 12
        count_seq(12, 15);
        exp_q.push_back({c_WRAP, 8'h01});
        tick(4'h0);
        chk("wrap1_total", wrap_total, 1);
        chk("wrap1_valid", event_valid, 1);

        // Threshold at 2 replaces WRAP, then ordinary WRAP again
        wrap_cycle(1'b1, c_THRESH, 8'h02);
        chk("thresh_total", wrap_total, 2);
        wrap_cycle(1'b1, c_WRAP, 8'h03);
        chk("wrap3_total", wrap_total, 3);

        // Sequence violation 5 -> 7
        count_seq(1, 5);
`ifdef COUNT_MONITOR_SKIP_CHECK_EN
        exp_q.push_back({c_SKIP, 8'h67});
        tick(4'h7);
        chk("skip_pulse", skip_err, 1);
`else
        tick(4'h7);
        chk("skip_pulse_off", skip_err, 0);
`endif
        tick(4'h8);
        chk("skip_deassert", skip_err, 0);
        tick(4'h9);
        chk("skip_after_9", skip_err, 0);
        count_seq(10, 15);
        chk("skip_queue_empty", exp_q.size(), 0);
        chk("skip_overflow", overflow, 0);
        chk("skip_total", wrap_total, 3);
        tick(4'h0);                         // wrap 4, drained later by reset
        exp_q.delete();
        event_ready = 1'b0;
        do_reset();

        // Overflow: 5 wraps into a 4-deep FIFO with ready low
        wrap_cycle(1'b1, c_WRAP,   8'h01);
        wrap_cycle(1'b1, c_THRESH, 8'h02);
        wrap_cycle(1'b1, c_WRAP,   8'h03);
        wrap_cycle(1'b1, c_WRAP,   8'h04);
        chk("full_no_drop", overflow, 0);
        wrap_cycle(1'b0, c_WRAP,   8'h05);
        chk("ovf_set",   overflow,   1);
        chk("ovf_total", wrap_total, 5);
        chk("ovf_head",  event_data, 8'h01);
        event_ready = 1'b1;
        count_seq(1, 4);
        chk("drain_empty", event_valid, 0);
        chk("drain_queue", exp_q.size(), 0);
        chk("ovf_sticky",  overflow, 1);

        // Full FIFO with push and pop in the same cycle
        event_ready = 1'b0;
        do_reset();
        wrap_cycle(1'b1, c_WRAP,   8'h01);
        wrap_cycle(1'b1, c_THRESH, 8'h02);
        wrap_cycle(1'b1, c_WRAP,   8'h03);
        wrap_cycle(1'b1, c_WRAP,   8'h04);
        count_seq(1, 15);
        event_ready = 1'b1;
        exp_q.push_back({c_WRAP, 8'h05});
        tick(4'h0);
        event_ready = 1'b0;
        chk("simul_no_drop", overflow, 0);
        chk("simul_head",    event_data, 8'h02);
        wrap_cycle(1'b0, c_WRAP, 8'h06);    // still full: this one drops
        chk("simul_still_full", overflow, 1);
        event_ready = 1'b1;
        count_seq(1, 4);
        chk("simul_drained", event_valid, 0);
        chk("simul_queue",   exp_q.size(), 0);

        // Reset in the middle of a stream with two records queued
        event_ready = 1'b0;
        count_seq(5, 15);
        tick(4'h0);
        wrap_cycle(1'b0, c_WRAP, 8'h08);
        chk("pre_rst_valid", event_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    event_valid, 0);
        chk("mid_rst_total",    wrap_total,  0);
        chk("mid_rst_overflow", overflow,    0);
        chk("mid_rst_data",     event_data,  0);
        @(negedge clk);
        rst         = 1'b0;
        event_ready = 1'b1;
        tick(4'h9);                          // SYNC sample, no check against 0
        tick(4'hA);
        chk("post_rst_no_skip", skip_err, 0);
        count_seq(11, 15);
        exp_q.push_back({c_WRAP, 8'h01});
        tick(4'h0);
        chk("post_rst_total", wrap_total, 1);
        count_seq(1, 2);
        chk("final_queue",    exp_q.size(), 0);
        chk("final_overflow", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_monitor.md
# count_monitor

Downstream consumer of the free-running 4-bit counter. Samples the counter value every clock and detects wrap-around (15→0). Keeps a running wrap total and optionally flags sequence violations. Queues event records in a small FIFO behind a valid/ready interface for a software-visible or logging stage.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event queue depth. Power of two, ≥2.
- `WRAP_THRESH`, default 8'd8: wrap-total value that raises a THRESH event.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst`, in, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `count_in`, in, 4: counter value, stable before each posedge.
- `event_valid`, out, 1: head FIFO record valid.
- `event_ready`, in, 1: consumer accepts the head record.
- `event_type`, out, 2: 01 WRAP, 10 SKIP, 11 THRESH; 00 never emitted.
- `event_data`, out, 8: record payload.
- `wrap_total`, out, 8: wraps since reset; wraps 255→0.
- `skip_err`, out, 1: one-cycle pulse on a detected skip.
- `overflow`, out, 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Reset values: `event_valid`=0, `event_type`=0, `event_data`=0, `wrap_total`=0, `skip_err`=0, `overflow`=0, FIFO empty, FSM=SYNC, `prev`=0.
- FSM:
  - SYNC: capture `count_in` into `prev`; no checks; go to TRACK.
  - TRACK: compare `count_in` against `prev` each edge, then update `prev`.
- Wrap: in TRACK with `prev`=15 and `count_in`=0.
  - `wrap_total` increments (mod 256).
  - If the new total equals `WRAP_THRESH`, push THRESH with data = new total.
  - Otherwise push WRAP with data = new total.
  - THRESH supersedes WRAP. Only one record is pushed per cycle.
- Skip (macro only): in TRACK with `count_in` ≠ (`prev`+1) mod 16.
  - A held value counts as a skip.
  - Push SKIP with data = {expected[3:0], observed[3:0]}.
  - Pulse `skip_err`; go to SYNC.
  - Wrap and skip are mutually exclusive by definition.
- FIFO:
  - Pop when `event_valid` && `event_ready`.
  - Push is accepted when not full, or when full and popping in the same cycle.
  - Otherwise the record is dropped and `overflow` is set. `overflow` clears only on `rst`.
- Head record is presented on `event_type`/`event_data` while `event_valid`=1. It holds stable until popped.
- Reset mid-operation: FIFO contents are discarded and all outputs return to reset values asynchronously.

## Timing
- Detection on sample edge N. The record is visible (`event_valid`=1 into an empty FIFO) after edge N: 1-cycle latency.
- `wrap_total` and `skip_err` update at edge N. `skip_err` deasserts at N+1 unless a new skip occurs.
- First sample after `rst` release is SYNC. Checking starts at the second edge.
- Empty FIFO: push at edge N, pop possible at edge N+1. No combinational bypass.
- Full FIFO: simultaneous push and pop keeps it full with no drop. Order is strictly FIFO.
- Ready may be asserted without valid; this has no effect.

## Configuration
- `COUNT_MONITOR_SKIP_CHECK_EN` defined: skip detection, SKIP records, `skip_err` pulses, and TRACK→SYNC on violation.
- Not defined:
  - Only `prev`=15 → `count_in`=0 is acted on; all other transitions are ignored.
  - `skip_err` is tied to 0 and no SKIP records are produced.
  - FSM stays in TRACK after the first sample.

## Test plan
- Reference counter drives `count_in`; `rst` for 10 time units; `event_ready`=1 → after its first 15→0 wrap: one WRAP record, data 8'h01, `wrap_total`=1; `skip_err`, `overflow` stay 0.
- `WRAP_THRESH`=2, ready=1, 2 wraps → WRAP data 01, then THRESH data 02 (no WRAP for the second); wrap 3 → WRAP data 03.
- Macro on: drive 4,5,7,8,9 → SKIP data 8'h67 and `skip_err` one cycle after the 7 is sampled; 8 is not checked (SYNC); 9 passes; no further records. Macro off: same stimulus → no records.
- `event_ready`=0, `FIFO_DEPTH`=4, 5 wraps → 4 records held, `overflow`=1. Raise ready → drains data 01,02,03,04 in order, one per cycle. `overflow` stays 1.
- FIFO full with a wrap pushed in the same cycle as a pop → no drop, still full, `overflow` unchanged, new record last in order.
- Assert `rst` mid-stream with 2 records queued → `event_valid`=0, `wrap_total`=0, `overflow`=0 immediately; after release, first sample is SYNC (no false skip).
